// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: refresh prescaler, digit scan,
// tear-free shadow commit at frame wrap, decimal points, blinking and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] num_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_done,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   sel
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        idx;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    phase;

    logic [4*NUM_DIGITS-1:0] act_num, pend_num;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
    logic [NUM_DIGITS-1:0]   act_blink, pend_blink;
    logic                    act_lz, pend_lz;

    logic                    tick, frame_wrap;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   sel_on;
    logic [3:0]              nibble;
    logic                    cur_dp, cur_blink, cur_lz;
    logic [6:0]              glyph;
    logic [6:0]              seg_on;
    logic                    dp_on;

    assign tick       = (prescaler == PRE_W'(SCAN_DIV - 1));
    assign frame_wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        zero_run  = 1'b1;
        lz_mask   = '0;
        sel_on    = '0;
        nibble    = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (act_num[4*k +: 4] == 4'h0);
            if (k != 0) lz_mask[k] = zero_run;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_on[k] = 1'b1;
                nibble    = act_num[4*k +: 4];
                cur_dp    = act_dp[k];
                cur_blink = act_blink[k];
                cur_lz    = lz_mask[k];
            end
        end
    end

    always_comb begin
        case (nibble)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
        seg_on = ((phase && cur_blink) || (act_lz && cur_lz)) ? 7'h00 : glyph;
        dp_on  = cur_dp && !(phase && cur_blink);
    end

    // Pending shadow is copied into the active shadow only at the frame wrap,
    // so a frame is never drawn from a mix of old and new data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler  <= '0;
            idx        <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            act_num    <= '0;
            act_dp     <= '0;
            act_blink  <= '0;
            act_lz     <= 1'b0;
            pend_num   <= '0;
            pend_dp    <= '0;
            pend_blink <= '0;
            pend_lz    <= 1'b0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            sel        <= SEL_OFF;
        end else begin
            prescaler  <= tick ? '0 : prescaler + 1'b1;
            frame_done <= frame_wrap;
            if (tick) begin
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            if (frame_wrap) begin
                if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
                if (pending) begin
                    act_num   <= pend_num;
                    act_dp    <= pend_dp;
                    act_blink <= pend_blink;
                    act_lz    <= pend_lz;
                end
            end
            if (load) begin
                pend_num   <= num_in;
                pend_dp    <= dp_in;
                pend_blink <= blink_in;
                pend_lz    <= lz_blank;
                pending    <= 1'b1;
            end else if (frame_wrap) begin
                pending <= 1'b0;
            end
            seg <= SEG_ACTIVE_LOW ? ~seg_on : seg_on;
            dp  <= SEG_ACTIVE_LOW ? ~dp_on : dp_on;
            sel <= SEL_ACTIVE_LOW ? ~sel_on : sel_on;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected digit slots are queued per frame
// and a monitor compares them each time the digit select moves.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BF    = 2;
    localparam int CLK_P = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  num_in = '0;
    logic [3:0]   dp_in = '0;
    logic [3:0]   blink_in = '0;
    logic         lz_blank = 1'b0;
    logic         load = 1'b0;
    logic         pending;
    logic         frame_done;
    logic [6:0]   seg;
    logic         dp;
    logic [3:0]   sel;

    logic [11:0]  exp_q[$];
    logic [11:0]  exp_front;
    logic [3:0]   prev_sel = 4'hF;
    int           errors = 0;
    int           checks = 0;
    time          t_frame;

    seg_scan_ctrl #(
        .NUM_DIGITS(N), .SCAN_DIV(DIV), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .num_in(num_in), .dp_in(dp_in),
        .blink_in(blink_in), .lz_blank(lz_blank), .load(load),
        .pending(pending), .frame_done(frame_done), .seg(seg), .dp(dp), .sel(sel)
    );

    always #(CLK_P/2) clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Each new digit slot is one DUT output event; it consumes one queued expectation.
    always @(negedge clk) begin
        if (!reset && sel !== prev_sel && exp_q.size() > 0) begin
            exp_front = exp_q.pop_front();
            checks++;
            if ({sel, seg, dp} !== exp_front) begin
                errors++;
                $display("[TB] FAIL slot at %0t: got sel=%b seg=0x%h dp=%b, required sel=%b seg=0x%h dp=%b",
                         $time, sel, seg, dp, exp_front[11:8], exp_front[7:1], exp_front[0]);
            end
        end
        prev_sel = sel;
    end

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dp_lit);
        check_output("queue drained before push", exp_q.size(), 0);
        exp_q.push_back({4'b1110, s0, ~dp_lit[0]});
        exp_q.push_back({4'b1101, s1, ~dp_lit[1]});
        exp_q.push_back({4'b1011, s2, ~dp_lit[2]});
        exp_q.push_back({4'b0111, s3, ~dp_lit[3]});
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 64);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: frame_done timeout, got 0, required 1", tag);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] num, input logic [3:0] dpv,
                                  input logic [3:0] blk, input logic lz);
        num_in   = num;
        dp_in    = dpv;
        blink_in = blk;
        lz_blank = lz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " sel"}, sel, 4'hF);
        check_output({tag, " seg"}, seg, 7'h7F);
        check_output({tag, " dp"}, dp, 1'b1);
        check_output({tag, " pending"}, pending, 1'b0);
        check_output({tag, " frame_done"}, frame_done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        reset = 1'b0;

        // Free-running scan of zeros and frame period
        wait_frame("b1");
        t_frame = $time;
        check_output("pending idle", pending, 1'b0);
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        wait_frame("b2");
        check_output("frame period", 32'($time - t_frame), 16 * CLK_P);
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);

        // Mid-frame load waits for the next frame
        repeat (4) @(negedge clk);
        apply_stimulus(16'h12AF, 4'b0000, 4'b0000, 1'b0);
        check_output("pending after load", pending, 1'b1);
        wait_frame("b3");
        check_output("pending after commit", pending, 1'b0);
        push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'b0000);

        // Two loads in one frame: last wins
        repeat (2) @(negedge clk);
        apply_stimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        apply_stimulus(16'h2222, 4'b0000, 4'b0000, 1'b0);
        wait_frame("b4");
        check_output("pending after b4", pending, 1'b0);
        push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'b0000);

        // Load on the boundary tick: old pending commits, new one stays pending
        repeat (3) @(negedge clk);
        apply_stimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
        repeat (11) @(negedge clk);
        apply_stimulus(16'h3333, 4'b0000, 4'b0000, 1'b0);
        check_output("frame_done on collision", frame_done, 1'b1);
        check_output("pending kept on collision", pending, 1'b1);
        push_frame(7'h79, 7'h79, 7'h79, 7'h79, 4'b0000);
        wait_frame("b6");
        check_output("pending after b6", pending, 1'b0);
        push_frame(7'h30, 7'h30, 7'h30, 7'h30, 4'b0000);

        // Leading-zero blanking
        repeat (2) @(negedge clk);
        apply_stimulus(16'h0040, 4'b0000, 4'b0000, 1'b1);
        wait_frame("b7");
        push_frame(7'h40, 7'h19, 7'h7F, 7'h7F, 4'b0000);
        repeat (2) @(negedge clk);
        apply_stimulus(16'h0000, 4'b0000, 4'b0000, 1'b1);
        wait_frame("b8");
        push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);

        // Blink on digit 0, decimal point on digit 1; phase flips every two frames
        repeat (2) @(negedge clk);
        apply_stimulus(16'h0000, 4'b0010, 4'b0001, 1'b0);
        for (int j = 9; j <= 14; j++) begin
            wait_frame("blink");
            push_frame((((j / 2) % 2) == 1) ? 7'h7F : 7'h40, 7'h40, 7'h40, 7'h40, 4'b0010);
        end

        // Async reset mid-frame discards the pending update
        wait_frame("b15");
        repeat (2) @(negedge clk);
        apply_stimulus(16'h5555, 4'b0000, 4'b0000, 1'b0);
        check_output("pending before reset", pending, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_state("mid-frame reset");
        num_in = '0;
        repeat (2) @(negedge clk);
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        reset = 1'b0;
        wait_frame("post-reset b1");
        check_output("pending discarded", pending, 1'b0);
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        wait_frame("post-reset b2");
        check_output("queue drained at end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
